// File: rtl/ili9341_spi_sink_pkg.sv
// Shared opcodes, geometry defaults and window type for the ILI9341 SPI sink.
package ili9341_spi_sink_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 240;
    localparam int unsigned DEFAULT_HEIGHT = 320;

    typedef enum logic [7:0] {
        ILI9341_NOP     = 8'h00,
        ILI9341_SWRESET = 8'h01,
        ILI9341_CASET   = 8'h2A,
        ILI9341_PASET   = 8'h2B,
        ILI9341_RAMWR   = 8'h2C
    } ILI9341_register_t;

    typedef struct packed {
        logic [15:0] sc;
        logic [15:0] ec;
        logic [15:0] sp;
        logic [15:0] ep;
    } window_t;

endpackage

// File: rtl/ili9341_spi_sink_rx_byte.sv
// SPI mode-0 byte receiver: synchronizes the SPI pins into clk and emits
// one byte_valid pulse per 8 sampled bits, with dc captured on the 8th edge.
module spi_peripheral_rx_byte (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_csb,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       data_commandb,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       dc
);

    // sync vectors are {csb, sclk, mosi, dc}
    logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic       sclk_prev_q, sclk_prev_d, csb_prev_q, csb_prev_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       dc_q, dc_d;
    logic       shift_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 4'b1000;
            sync2_q      <= 4'b1000;
            sclk_prev_q  <= 1'b0;
            csb_prev_q   <= 1'b1;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            byte_valid_q <= 1'b0;
            rx_byte_q    <= 8'd0;
            dc_q         <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sclk_prev_q  <= sclk_prev_d;
            csb_prev_q   <= csb_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_valid_q <= byte_valid_d;
            rx_byte_q    <= rx_byte_d;
            dc_q         <= dc_d;
        end
    end

    always_comb begin
        sync1_d      = {spi_csb, spi_clk, spi_mosi, data_commandb};
        sync2_d      = sync1_q;
        sclk_prev_d  = sync2_q[2];
        csb_prev_d   = sync2_q[3];
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_valid_d = 1'b0;
        rx_byte_d    = rx_byte_q;
        dc_d         = dc_q;
        // csb rising together with the last edge still counts as selected
        shift_en     = sync2_q[2] && !sclk_prev_q && !(sync2_q[3] && csb_prev_q);
        if (shift_en) begin
            shift_d   = {shift_q[6:0], sync2_q[1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                rx_byte_d    = {shift_q[6:0], sync2_q[1]};
                dc_d         = sync2_q[0];
            end
        end else if (sync2_q[3]) begin
            bit_cnt_d = 3'd0;
        end
    end

    assign byte_valid = byte_valid_q;
    assign rx_byte    = rx_byte_q;
    assign dc         = dc_q;

endmodule

// File: rtl/ili9341_spi_sink.sv
// ILI9341 display model: decodes the command/data stream and turns RAMWR
// pixels into VRAM write strobes within the CASET/PASET window.
module ili9341_spi_sink
    import ili9341_spi_sink_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned DISPLAY_HEIGHT = DEFAULT_HEIGHT,
    parameter int unsigned VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_csb,
    input  logic                       spi_clk,
    input  logic                       spi_mosi,
    input  logic                       data_commandb,
    output logic                       spi_miso,
    output logic                       cmd_valid,
    output logic [7:0]                 cmd_byte,
    output logic                       vram_wr_ena,
    output logic [$clog2(VRAM_L)-1:0]  vram_wr_addr,
    output logic [15:0]                vram_wr_data,
    output logic                       frame_done,
    output logic                       range_error
);

    localparam int unsigned AW = $clog2(VRAM_L);
    localparam window_t WIN_RST = '{sc: 16'd0, ec: 16'(DISPLAY_WIDTH - 1),
                                    sp: 16'd0, ep: 16'(DISPLAY_HEIGHT - 1)};

    typedef enum logic [2:0] {
        S_IDLE, S_CASET, S_PASET, S_RAMWR_HI, S_RAMWR_LO, S_IGNORE
    } state_t;

    logic       byte_valid, dc;
    logic [7:0] rx_byte;

    spi_peripheral_rx_byte u_rx (
        .clk           (clk),
        .rst           (rst),
        .spi_csb       (spi_csb),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .data_commandb (data_commandb),
        .byte_valid    (byte_valid),
        .rx_byte       (rx_byte),
        .dc            (dc)
    );

    state_t          state_q, state_d;
    window_t         win_q, win_d;
    logic [15:0]     x_q, x_d, y_q, y_d;
    logic [1:0]      param_cnt_q, param_cnt_d;
    logic [23:0]     param_q, param_d;
    logic [7:0]      pix_hi_q, pix_hi_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [7:0]      cmd_byte_q, cmd_byte_d;
    logic            wr_ena_q, wr_ena_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]     wr_data_q, wr_data_d;
    logic            frame_done_q, frame_done_d;
    logic            range_error_q, range_error_d;
    logic [31:0]     addr_full;
    logic            in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            win_q         <= WIN_RST;
            x_q           <= 16'd0;
            y_q           <= 16'd0;
            param_cnt_q   <= 2'd0;
            param_q       <= 24'd0;
            pix_hi_q      <= 8'd0;
            cmd_valid_q   <= 1'b0;
            cmd_byte_q    <= 8'd0;
            wr_ena_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 16'd0;
            frame_done_q  <= 1'b0;
            range_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            x_q           <= x_d;
            y_q           <= y_d;
            param_cnt_q   <= param_cnt_d;
            param_q       <= param_d;
            pix_hi_q      <= pix_hi_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_byte_q    <= cmd_byte_d;
            wr_ena_q      <= wr_ena_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            range_error_q <= range_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        x_d           = x_q;
        y_d           = y_q;
        param_cnt_d   = param_cnt_q;
        param_d       = param_q;
        pix_hi_d      = pix_hi_q;
        cmd_valid_d   = 1'b0;
        cmd_byte_d    = cmd_byte_q;
        wr_ena_d      = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        range_error_d = range_error_q;
        // widen before multiply so large y*W never truncates
        addr_full     = 32'(y_q) * 32'(DISPLAY_WIDTH) + 32'(x_q);
        in_range      = (32'(x_q) < 32'(DISPLAY_WIDTH)) && (32'(y_q) < 32'(DISPLAY_HEIGHT))
                        && (win_q.sc <= win_q.ec) && (win_q.sp <= win_q.ep);

        if (byte_valid && !dc) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = rx_byte;
            param_cnt_d = 2'd0;
            case (rx_byte)
                ILI9341_NOP:   ;
                ILI9341_CASET: state_d = S_CASET;
                ILI9341_PASET: state_d = S_PASET;
                ILI9341_RAMWR: begin
                    state_d = S_RAMWR_HI;
                    x_d     = win_q.sc;
                    y_d     = win_q.sp;
                end
                ILI9341_SWRESET: begin
                    state_d       = S_IDLE;
                    win_d         = WIN_RST;
                    range_error_d = 1'b0;
                end
                default: state_d = S_IGNORE;
            endcase
        end else if (byte_valid) begin
            case (state_q)
                S_CASET, S_PASET: begin
                    if (param_cnt_q == 2'd3) begin
                        if (state_q == S_CASET) begin
                            win_d.sc = param_q[23:8];
                            win_d.ec = {param_q[7:0], rx_byte};
                        end else begin
                            win_d.sp = param_q[23:8];
                            win_d.ep = {param_q[7:0], rx_byte};
                        end
                        param_cnt_d = 2'd0;
                        state_d     = S_IDLE;
                    end else begin
                        param_d     = {param_q[15:0], rx_byte};
                        param_cnt_d = param_cnt_q + 2'd1;
                    end
                end
                S_RAMWR_HI: begin
                    pix_hi_d = rx_byte;
                    state_d  = S_RAMWR_LO;
                end
                S_RAMWR_LO: begin
                    if (in_range) begin
                        wr_ena_d  = 1'b1;
                        wr_addr_d = AW'(addr_full);
                        wr_data_d = {pix_hi_q, rx_byte};
                    end else begin
                        range_error_d = 1'b1;
                    end
                    if (x_q == win_q.ec) begin
                        x_d = win_q.sc;
                        if (y_q == win_q.ep) begin
                            y_d          = win_q.sp;
                            frame_done_d = in_range;
                        end else begin
                            y_d = y_q + 16'd1;
                        end
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                    state_d = S_RAMWR_HI;
                end
                default: ;
            endcase
        end
    end

    assign spi_miso     = 1'b0;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_byte     = cmd_byte_q;
    assign vram_wr_ena  = wr_ena_q;
    assign vram_wr_addr = wr_addr_q;
    assign vram_wr_data = wr_data_q;
    assign frame_done   = frame_done_q;
    assign range_error  = range_error_q;

endmodule

// File: tb/tb_ili9341_spi_sink.sv
// Directed bench for ili9341_spi_sink: drives SPI bytes and checks decoded
// commands, VRAM write addresses/data, frame_done and range_error.
module tb_ili9341_spi_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_csb, spi_clk, spi_mosi, data_commandb;
    logic        spi_miso, cmd_valid, vram_wr_ena, frame_done, range_error;
    logic [7:0]  cmd_byte;
    logic [16:0] vram_wr_addr;
    logic [15:0] vram_wr_data;

    int n_checks = 0;
    int n_pass   = 0;

    int       cmd_cnt = 0;
    int       fd_cnt  = 0;
    bit       bv_prev = 1'b0;
    int       wr_addr_log[$];
    int       wr_data_log[$];
    bit       wr_fd_log[$];
    bit       wr_lat_log[$];

    always #5 clk = ~clk;

    ili9341_spi_sink dut (
        .clk           (clk),
        .rst           (rst),
        .spi_csb       (spi_csb),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .data_commandb (data_commandb),
        .spi_miso      (spi_miso),
        .cmd_valid     (cmd_valid),
        .cmd_byte      (cmd_byte),
        .vram_wr_ena   (vram_wr_ena),
        .vram_wr_addr  (vram_wr_addr),
        .vram_wr_data  (vram_wr_data),
        .frame_done    (frame_done),
        .range_error   (range_error)
    );

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (vram_wr_ena) begin
                wr_addr_log.push_back(int'(vram_wr_addr));
                wr_data_log.push_back(int'(vram_wr_data));
                wr_fd_log.push_back(frame_done);
                wr_lat_log.push_back(bv_prev);
            end
            if (frame_done) fd_cnt++;
            if (cmd_valid) cmd_cnt++;
        end
        bv_prev = dut.u_rx.byte_valid_q;
    end

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        wr_fd_log.delete();
        wr_lat_log.delete();
        cmd_cnt = 0;
        fd_cnt  = 0;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dcv, input int nbits, input bit early_csb);
        @(negedge clk);
        spi_csb = 1'b0;
        data_commandb = dcv;
        repeat (2) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            repeat (2) @(negedge clk);
            spi_clk = 1'b1;
            if (early_csb && i == nbits - 1) spi_csb = 1'b1;
            repeat (2) @(negedge clk);
            spi_clk = 1'b0;
        end
        repeat (2) @(negedge clk);
        spi_csb = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_bits(b, 1'b0, 8, 1'b0);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_bits(b, 1'b1, 8, 1'b0);
    endtask

    task automatic send_pixel(input logic [15:0] p);
        send_data(p[15:8]);
        send_data(p[7:0]);
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_csb = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; data_commandb = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({spi_miso, cmd_valid, cmd_byte, vram_wr_ena, vram_wr_addr, vram_wr_data, frame_done, range_error} !== '0)
            $display("FAIL reset_outputs: got cmd_byte=%h addr=%0d data=%h flags=%b%b%b%b%b",
                     cmd_byte, vram_wr_addr, vram_wr_data, spi_miso, cmd_valid, vram_wr_ena, frame_done, range_error);
        else n_pass++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (dut.state_q !== 3'd0) $display("FAIL reset_state: got %0d want 0", dut.state_q);
        else n_pass++;
    endtask

    task automatic test_cmd();
        clear_logs();
        send_cmd(8'h2C);
        n_checks++;
        if (cmd_cnt !== 1) $display("FAIL cmd_pulse_count: got %0d want 1", cmd_cnt);
        else n_pass++;
        n_checks++;
        if (cmd_byte !== 8'h2C) $display("FAIL cmd_byte: got %h want 2c", cmd_byte);
        else n_pass++;
        n_checks++;
        if (wr_addr_log.size() !== 0) $display("FAIL cmd_no_write: got %0d writes want 0", wr_addr_log.size());
        else n_pass++;
    endtask

    task automatic test_single_pixel();
        clear_logs();
        send_cmd(8'h2C);
        send_pixel(16'hF800);
        n_checks++;
        if (wr_addr_log.size() !== 1) $display("FAIL single_count: got %0d want 1", wr_addr_log.size());
        else begin
            n_pass++;
            n_checks++;
            if (wr_addr_log[0] !== 0 || wr_data_log[0] !== 32'hF800)
                $display("FAIL single_write: got addr=%0d data=%h want addr=0 data=f800", wr_addr_log[0], wr_data_log[0]);
            else n_pass++;
            n_checks++;
            if (wr_lat_log[0] !== 1'b1) $display("FAIL single_latency: byte_valid prev cycle=%0d want 1", wr_lat_log[0]);
            else n_pass++;
        end
    endtask

    // Writes a window, streams pixels and checks addresses and frame_done placement
    task automatic run_window(input string name, input logic [7:0] cas[4], input logic [7:0] pas[4],
                              input int exp_addr[], input int fd_idx);
        clear_logs();
        send_cmd(8'h2A);
        for (int i = 0; i < 4; i++) send_data(cas[i]);
        send_cmd(8'h2B);
        for (int i = 0; i < 4; i++) send_data(pas[i]);
        send_cmd(8'h2C);
        for (int i = 0; i < exp_addr.size(); i++) send_pixel(16'h1200 + 16'(i));
        n_checks++;
        if (wr_addr_log.size() !== exp_addr.size())
            $display("FAIL %s_count: got %0d want %0d", name, wr_addr_log.size(), exp_addr.size());
        else begin
            n_pass++;
            for (int i = 0; i < exp_addr.size(); i++) begin
                n_checks++;
                if (wr_addr_log[i] !== exp_addr[i] || wr_data_log[i] !== 32'h1200 + i
                    || wr_fd_log[i] !== (i == fd_idx) || wr_lat_log[i] !== 1'b1)
                    $display("FAIL %s_write%0d: got addr=%0d data=%h fd=%0d lat=%0d want addr=%0d data=%h fd=%0d lat=1",
                             name, i, wr_addr_log[i], wr_data_log[i], wr_fd_log[i], wr_lat_log[i],
                             exp_addr[i], 32'h1200 + i, (i == fd_idx));
                else n_pass++;
            end
        end
        n_checks++;
        if (fd_cnt !== 1) $display("FAIL %s_frame_done_count: got %0d want 1", name, fd_cnt);
        else n_pass++;
    endtask

    task automatic test_window();
        logic [7:0] cas[4] = '{8'h00, 8'd10, 8'h00, 8'd11};
        logic [7:0] pas[4] = '{8'h00, 8'd5, 8'h00, 8'd6};
        int exp_a[] = '{1210, 1211, 1450, 1451, 1210};
        run_window("window", cas, pas, exp_a, 3);
    endtask

    task automatic test_frame_end();
        logic [7:0] cas[4] = '{8'h00, 8'hEC, 8'h00, 8'hEF};
        logic [7:0] pas[4] = '{8'h01, 8'h3E, 8'h01, 8'h3F};
        int exp_a[] = '{76556, 76557, 76558, 76559, 76796, 76797, 76798, 76799, 76556};
        run_window("frame_end", cas, pas, exp_a, 7);
    endtask

    task automatic test_range();
        send_cmd(8'h01);
        clear_logs();
        send_cmd(8'h2A);
        send_data(8'h00); send_data(8'hC8); send_data(8'h01); send_data(8'h00);
        send_cmd(8'h2C);
        for (int i = 0; i < 40; i++) send_pixel(16'h0100 + 16'(i));
        n_checks++;
        if (range_error !== 1'b0) $display("FAIL range_before: got %0d want 0", range_error);
        else n_pass++;
        send_pixel(16'hAAAA);
        send_pixel(16'hBBBB);
        n_checks++;
        if (wr_addr_log.size() !== 40) $display("FAIL range_count: got %0d want 40", wr_addr_log.size());
        else begin
            n_pass++;
            n_checks++;
            if (wr_addr_log[0] !== 200 || wr_addr_log[39] !== 239 || wr_data_log[39] !== 32'h0127)
                $display("FAIL range_edges: got first=%0d last=%0d data=%h want 200 239 0127",
                         wr_addr_log[0], wr_addr_log[39], wr_data_log[39]);
            else n_pass++;
        end
        n_checks++;
        if (range_error !== 1'b1) $display("FAIL range_set: got %0d want 1", range_error);
        else n_pass++;
        send_cmd(8'h01);
        n_checks++;
        if (range_error !== 1'b0) $display("FAIL range_swreset: got %0d want 0", range_error);
        else n_pass++;
    endtask

    task automatic test_partial();
        clear_logs();
        send_cmd(8'h2A);
        send_data(8'h00);
        send_data(8'h05);
        send_cmd(8'h2C);
        send_pixel(16'hABCD);
        n_checks++;
        if (wr_addr_log.size() !== 1 || wr_addr_log[0] !== 0 || wr_data_log[0] !== 32'hABCD)
            $display("FAIL partial_caset: got %0d writes addr=%0d want 1 write addr=0 data=abcd",
                     wr_addr_log.size(), (wr_addr_log.size() > 0) ? wr_addr_log[0] : -1);
        else n_pass++;
        clear_logs();
        send_bits(8'hFF, 1'b0, 5, 1'b0);
        send_cmd(8'h2A);
        n_checks++;
        if (cmd_cnt !== 1 || cmd_byte !== 8'h2A)
            $display("FAIL partial_bits: got cnt=%0d byte=%h want cnt=1 byte=2a", cmd_cnt, cmd_byte);
        else n_pass++;
        send_bits(8'h2B, 1'b0, 8, 1'b1);
        n_checks++;
        if (cmd_cnt !== 2 || cmd_byte !== 8'h2B)
            $display("FAIL csb_same_edge: got cnt=%0d byte=%h want cnt=2 byte=2b", cmd_cnt, cmd_byte);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cmd();
        test_single_pixel();
        test_window();
        test_frame_end();
        test_range();
        test_partial();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
